// File: rtl/ila_refinement_monitor.sv
// Per-instruction refinement verdict monitor for the oc8051 ILA-vs-RTL wrapper.
// Turns start / commit / match strobes into one sticky verdict: pass, fail, timeout or vacuous.
module ila_refinement_monitor #(
  parameter int NUM_MAPS   = 30,
  parameter int MAX_CYCLES = 132,
  parameter int CNT_W      = 8,
  parameter int IDX_W      = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                pc_change_i,
  input  logic                ila_valid_i,
  input  logic [NUM_MAPS-1:0] match_i,
  output logic [1:0]          state_o,
  output logic [CNT_W-1:0]    cycle_cnt_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic                fail_o,
  output logic                timeout_o,
  output logic                vacuous_o,
  output logic [NUM_MAPS-1:0] mismatch_vec_o,
  output logic [IDX_W-1:0]    first_fail_idx_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CYCLES);

  state_t              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                done_reg;
  logic                pass_reg;
  logic                fail_reg;
  logic                timeout_reg;
  logic                vacuous_reg;
  logic [NUM_MAPS-1:0] mismatch_reg;
  logic [IDX_W-1:0]    idx_reg;

  logic [NUM_MAPS-1:0] miss_vec;
  logic [IDX_W-1:0]    first_idx_next;

  assign miss_vec = ~match_i;

  // Scan from the top so the lowest failing map wins.
  always_comb begin
    first_idx_next = '0;
    for (int i = NUM_MAPS - 1; i >= 0; i--) begin
      if (miss_vec[i]) first_idx_next = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      done_reg     <= 1'b0;
      pass_reg     <= 1'b0;
      fail_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
      vacuous_reg  <= 1'b0;
      mismatch_reg <= '0;
      idx_reg      <= '0;
    end else begin
      done_reg <= 1'b0;
      unique case (state_reg)
        IDLE, DONE: begin
          if (start_i) begin
            state_reg    <= RUN;
            cnt_reg      <= '0;
            pass_reg     <= 1'b0;
            fail_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
            vacuous_reg  <= 1'b0;
            mismatch_reg <= '0;
            idx_reg      <= '0;
          end
        end
        RUN: begin
          // Commit beats timeout; the counter freezes on the commit edge.
          if (pc_change_i) begin
            state_reg <= CHECK;
          end else if (cnt_reg == CNT_MAX) begin
            state_reg    <= DONE;
            done_reg     <= 1'b1;
            timeout_reg  <= 1'b1;
            fail_reg     <= 1'b1;
            mismatch_reg <= '0;
            idx_reg      <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        CHECK: begin
          state_reg <= DONE;
          done_reg  <= 1'b1;
          if (!ila_valid_i) begin
            vacuous_reg <= 1'b1;
          end else if (&match_i) begin
            pass_reg <= 1'b1;
          end else begin
            fail_reg     <= 1'b1;
            mismatch_reg <= miss_vec;
            idx_reg      <= first_idx_next;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign state_o          = state_reg;
  assign cycle_cnt_o      = cnt_reg;
  assign busy_o           = (state_reg == RUN) || (state_reg == CHECK);
  assign done_o           = done_reg;
  assign pass_o           = pass_reg;
  assign fail_o           = fail_reg;
  assign timeout_o        = timeout_reg;
  assign vacuous_o        = vacuous_reg;
  assign mismatch_vec_o   = mismatch_reg;
  assign first_fail_idx_o = idx_reg;

endmodule

// File: tb/tb_ila_refinement_monitor.sv
// Bench for ila_refinement_monitor: directed and random instructions checked against
// a transaction-level verdict model.
module tb_ila_refinement_monitor;
  localparam int NM = 30;
  localparam int MC = 132;
  localparam int CW = 8;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          pc_change_i;
  logic          ila_valid_i;
  logic [NM-1:0] match_i;
  logic [1:0]    state_o;
  logic [CW-1:0] cycle_cnt_o;
  logic          busy_o;
  logic          done_o;
  logic          pass_o;
  logic          fail_o;
  logic          timeout_o;
  logic          vacuous_o;
  logic [NM-1:0] mismatch_vec_o;
  logic [IW-1:0] first_fail_idx_o;

  int errors = 0;
  int checks = 0;
  logic [NM-1:0] m2;
  logic [NM-1:0] mr;

  ila_refinement_monitor #(.NUM_MAPS(NM), .MAX_CYCLES(MC), .CNT_W(CW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .pc_change_i(pc_change_i),
    .ila_valid_i(ila_valid_i), .match_i(match_i), .state_o(state_o),
    .cycle_cnt_o(cycle_cnt_o), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .fail_o(fail_o), .timeout_o(timeout_o), .vacuous_o(vacuous_o),
    .mismatch_vec_o(mismatch_vec_o), .first_fail_idx_o(first_fail_idx_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [NM-1:0] v);
    for (int i = 0; i < NM; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One instruction: commit = RUN cycle (1-based) carrying pc_change_i, 0 = never.
  task automatic run_txn(input int commit, input logic [NM-1:0] m, input logic v);
    int eff, done_at, exp_done, exp_cnt;
    bit ok, vck, allm;
    logic [NM-1:0] e_mv;
    eff = (commit >= 1 && commit <= MC + 1) ? commit : 0;
    ok = (eff != 0);
    start_i = 1'b1; pc_change_i = 1'b0; match_i = NM'($urandom); ila_valid_i = 1'($urandom);
    tick();
    chk("start_state", state_o, 1);
    chk("start_cnt", cycle_cnt_o, 0);
    chk("start_flags", {done_o, pass_o, fail_o, timeout_o, vacuous_o}, 0);
    chk("start_mvec", mismatch_vec_o, 0);
    chk("start_idx", first_fail_idx_o, 0);
    done_at = 0;
    for (int k = 1; k <= 200 && done_at == 0; k++) begin
      start_i = 1'($urandom);
      pc_change_i = (k == eff);
      if (ok && k == eff + 1) begin
        match_i = m; ila_valid_i = v;
        chk("check_state", {state_o, busy_o, cycle_cnt_o}, {2'd2, 1'b1, CW'(eff - 1)});
      end else begin
        match_i = NM'($urandom); ila_valid_i = 1'($urandom);
        chk("run_state", {state_o, busy_o, cycle_cnt_o}, {2'd1, 1'b1, CW'(k - 1)});
      end
      tick();
      if (done_o) done_at = k;
    end
    exp_done = ok ? eff + 1 : MC + 1;
    chk("latency", done_at, exp_done);
    vck  = ok && v;
    allm = &m;
    e_mv = (vck && !allm) ? ~m : '0;
    exp_cnt = ok ? eff - 1 : MC;
    chk("done_state", state_o, 3);
    chk("cnt", cycle_cnt_o, exp_cnt);
    chk("pass", pass_o, vck && allm);
    chk("fail", fail_o, !ok || (vck && !allm));
    chk("timeout", timeout_o, !ok);
    chk("vacuous", vacuous_o, ok && !v);
    chk("mvec", mismatch_vec_o, e_mv);
    chk("idx", first_fail_idx_o, lowest(e_mv));
    start_i = 1'b0; pc_change_i = 1'b1; match_i = NM'($urandom); ila_valid_i = 1'($urandom);
    tick();
    pc_change_i = 1'b0;
    chk("hold_done", {state_o, done_o, busy_o}, {2'd3, 1'b0, 1'b0});
    chk("hold_verdict", {pass_o, fail_o, timeout_o, vacuous_o, cycle_cnt_o},
        {vck && allm, !ok || (vck && !allm), !ok, ok && !v, CW'(exp_cnt)});
    chk("hold_mvec", mismatch_vec_o, e_mv);
    $display("txn commit=%0d valid=%0d match=%08h latency=%0d pass=%0d fail=%0d to=%0d vac=%0d idx=%0d",
             commit, v, m, done_at, pass_o, fail_o, timeout_o, vacuous_o, first_fail_idx_o);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; pc_change_i = 1'b0; ila_valid_i = 1'b0; match_i = '0;
    tick(); tick();
    chk("rst_state", {state_o, busy_o, done_o, cycle_cnt_o}, 0);
    chk("rst_flags", {pass_o, fail_o, timeout_o, vacuous_o, mismatch_vec_o, first_fail_idx_o}, 0);
    rst = 1'b0;
    pc_change_i = 1'b1;
    tick();
    pc_change_i = 1'b0;
    chk("idle_ignore_pc", state_o, 0);

    m2 = '1; m2[12] = 1'b0; m2[27] = 1'b0;
    run_txn(4, '1, 1'b1);
    run_txn(4, m2, 1'b1);
    run_txn(0, '1, 1'b1);
    run_txn(MC + 1, '1, 1'b1);
    run_txn(MC + 1, m2, 1'b1);
    run_txn(4, m2, 1'b0);
    run_txn(1, '1, 1'b1);

    for (int t = 0; t < 20; t++) begin
      case ($urandom_range(0, 2))
        0: mr = '1;
        1: begin mr = '1; mr[$urandom_range(0, NM - 1)] = 1'b0; end
        default: mr = NM'($urandom);
      endcase
      run_txn(($urandom_range(0, 3) == 0) ? $urandom_range(0, 140) : $urandom_range(1, 12),
              mr, ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset in the middle of an instruction.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (49) tick();
    chk("pre_rst_cnt", {state_o, cycle_cnt_o}, {2'd1, CW'(49)});
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {state_o, busy_o, done_o, cycle_cnt_o}, 0);
    chk("async_rst_flags", {pass_o, fail_o, timeout_o, vacuous_o, mismatch_vec_o, first_fail_idx_o}, 0);
    tick();
    rst = 1'b0;
    pc_change_i = 1'b1;
    tick();
    pc_change_i = 1'b0;
    chk("post_rst_pc", {state_o, cycle_cnt_o}, 0);
    tick();
    chk("post_rst_idle", {state_o, done_o}, 0);
    $display("txn async_rst state=%0d cnt=%0d", state_o, cycle_cnt_o);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
